// File: rtl/mult_sched_pkg.sv
// Shared types and default parameters for the multiplier job scheduler.
package mult_sched_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_START_CYCLES = 1;
  localparam int DEF_TIMEOUT      = 64;
endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand-pair FIFO; power-of-two DEPTH so pointers wrap for free.
module mult_op_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/mult_job_scheduler.sv
// Queues operand pairs and feeds them one at a time to an external
// shift-add multiplier, with a WAIT timeout that returns an error result.
module mult_job_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mult_start,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_err,
  output logic               busy
);
  // One counter serves both ISSUE (start hold) and WAIT (timeout).
  localparam int CNT_W = $clog2(TIMEOUT + 16);

  sched_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;

  mult_op_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .din_i   ({in_a, in_b}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          {a_d, b_d} = fifo_dout;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        // done wins over a simultaneous timeout
        if (mult_done) begin
          prod_d  = mult_product;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign mult_start  = (state_q == S_ISSUE);
  assign mult_a      = a_q;
  assign mult_b      = b_q;
  assign out_valid   = (state_q == S_RESP);
  assign out_product = prod_q;
  assign out_err     = err_q;
  assign busy        = (state_q != S_IDLE) || (|fifo_count);
endmodule

// File: tb/tb_mult_job_scheduler.sv
// Directed bench: behavioural multiplier model drives the default instance;
// a second instance with START_CYCLES=5 sees a held-high done.
module tb_mult_job_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b, mult_a, mult_b;
  logic        mult_start, mult_done, out_valid, out_ready, out_err, busy;
  logic [15:0] mult_product, out_product;

  logic        b_in_valid, b_in_ready, b_mult_start, b_mult_done;
  logic [7:0]  b_in_a, b_in_b, b_mult_a, b_mult_b;
  logic [15:0] b_mult_product, b_out_product;
  logic        b_out_valid, b_out_ready, b_out_err, b_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_job_scheduler u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mult_start(mult_start), .mult_a(mult_a),
    .mult_b(mult_b), .mult_done(mult_done), .mult_product(mult_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_err(out_err), .busy(busy)
  );

  mult_job_scheduler #(.START_CYCLES(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .mult_start(b_mult_start), .mult_a(b_mult_a),
    .mult_b(b_mult_b), .mult_done(b_mult_done), .mult_product(b_mult_product),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_product(b_out_product),
    .out_err(b_out_err), .busy(b_busy)
  );

  // Multiplier model: latches operands on start, pulses done mdl_dly edges later.
  int          mdl_dly;
  logic        mdl_never, mdl_busy, mdl_done, man_done;
  int          mdl_cnt;
  logic [15:0] mdl_prod;
  int          start_cyc;

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0; mdl_cnt <= 0; mdl_done <= 1'b0; mdl_prod <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (!mdl_busy) begin
        if (mult_start && !mdl_never) begin
          mdl_busy <= 1'b1; mdl_cnt <= 0;
          mdl_prod <= 16'(mult_a) * 16'(mult_b);
        end
      end else if (mdl_cnt == mdl_dly - 1) begin
        mdl_done <= 1'b1; mdl_busy <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) start_cyc <= 0;
    else if (mult_start) start_cyc <= start_cyc + 1;
  end

  assign mult_done    = mdl_done | man_done;
  assign mult_product = mdl_prod;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at a negedge with out_ready=1; consumes one result.
  task automatic get_res(input string tag, input logic [15:0] p, input logic e);
    int n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_prod"}, {16'd0, out_product}, {16'd0, p});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, e});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int s0, n, nv, ns;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    man_done = 1'b0; mdl_never = 1'b0; mdl_dly = 9;
    b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_mult_done = 1'b0;
    b_mult_product = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, mult_start}, 32'd0);
    chk("rst_prod", {16'd0, out_product}, 32'd0);
    chk("rst_ab", {16'd0, mult_a, mult_b}, 32'd0);

    // single job, latency to mult_start, start width
    out_ready = 1'b1; s0 = start_cyc;
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    chk("lat_start_early", {31'd0, mult_start}, 32'd0);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lat_start", {31'd0, mult_start}, 32'd1);
    chk("lat_a", {24'd0, mult_a}, 32'd7);
    get_res("single", 16'd49, 1'b0);
    chk("single_vld_low", {31'd0, out_valid}, 32'd0);
    chk("single_starts", start_cyc - s0, 32'd1);

    // burst: 5 back-to-back pairs
    mdl_dly = 3;
    push(8'd3, 8'd5); push(8'd255, 8'd255); push(8'd0, 8'd9);
    push(8'd12, 8'd10); push(8'd1, 8'd1);
    chk("burst_full", {31'd0, in_ready}, 32'd0);
    get_res("b0", 16'd15, 1'b0);
    get_res("b1", 16'd65025, 1'b0);
    get_res("b2", 16'd0, 1'b0);
    get_res("b3", 16'd120, 1'b0);
    get_res("b4", 16'd1, 1'b0);

    // backpressure in RESP while the queue fills
    out_ready = 1'b0; mdl_dly = 2;
    push(8'd2, 8'd3);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_vld", {31'd0, out_valid}, 32'd1);
    push(8'd1, 8'd2); push(8'd3, 8'd3); push(8'd10, 8'd10); push(8'd255, 8'd2);
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    s0 = start_cyc;
    repeat (20) @(negedge clk);
    chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_prod", {16'd0, out_product}, 32'd6);
    chk("bp_no_start", start_cyc - s0, 32'd0);
    out_ready = 1'b1;
    get_res("bp0", 16'd6, 1'b0);
    get_res("bp1", 16'd2, 1'b0);
    get_res("bp2", 16'd9, 1'b0);
    get_res("bp3", 16'd100, 1'b0);
    get_res("bp4", 16'd510, 1'b0);

    // timeout: 64 WAIT cycles then error result
    mdl_never = 1'b1;
    push(8'd5, 8'd5);
    n = 0;
    while (!mult_start && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 200);
    chk("to_cycles", n, 32'd65);
    get_res("to", 16'd0, 1'b1);
    mdl_never = 1'b0; mdl_dly = 4;
    push(8'd6, 8'd7);
    get_res("after_to", 16'd42, 1'b0);

    // done in the same cycle as expiry wins
    mdl_dly = 63;
    push(8'd9, 8'd9);
    get_res("edge_to", 16'd81, 1'b0);

    // reset mid-WAIT with two queued, then a stray done
    mdl_never = 1'b1;
    push(8'd2, 8'd2); push(8'd3, 8'd3); push(8'd4, 8'd4);
    repeat (5) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    man_done = 1'b1; @(negedge clk); man_done = 1'b0;
    nv = 0;
    repeat (10) begin @(negedge clk); if (out_valid) nv++; end
    chk("rr_no_vld", nv, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_in_ready", {31'd0, in_ready}, 32'd1);
    mdl_never = 1'b0; mdl_dly = 4;
    push(8'd6, 8'd4);
    get_res("rr_job", 16'd24, 1'b0);

    // START_CYCLES=5 with done held high from before ISSUE
    b_in_valid = 1'b1; b_in_a = 8'd11; b_in_b = 8'd3; b_mult_product = 16'd33;
    @(posedge clk); @(negedge clk); b_in_valid = 1'b0;
    b_mult_done = 1'b1;
    ns = 0; nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (b_mult_start) ns++;
      if (b_out_valid) begin
        nv++;
        chk("s5_prod", {16'd0, b_out_product}, 32'd33);
        chk("s5_err", {31'd0, b_out_err}, 32'd0);
        chk("s5_after_start", ns, 32'd5);
      end
    end
    b_mult_done = 1'b0;
    chk("s5_starts", ns, 32'd5);
    chk("s5_results", nv, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
